// File: rtl/fccc_apb_reconfig_master.sv
// APB initiator for the CCC/PLL dynamic-configuration port: one register access per command,
// gated by BUSY, optionally followed by a PLL lock-stability wait; response held until accepted.
module fccc_apb_reconfig_master #(
   parameter int unsigned LOCK_STABLE = 16,
   parameter int unsigned TIMEOUT     = 65535,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       i_pclk,
   input  logic       i_preset,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic       i_cmd_write,
   input  logic [5:0] i_cmd_addr,
   input  logic [7:0] i_cmd_wdata,
   input  logic       i_cmd_waitlock,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_rdata,
   output logic       o_rsp_err,
   output logic       o_ccc_preset_n,
   output logic       o_psel,
   output logic       o_penable,
   output logic       o_pwrite,
   output logic [5:0] o_paddr,
   output logic [7:0] o_pwdata,
   input  logic [7:0] i_prdata,
   input  logic       i_busy,
   input  logic       i_lock
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_BUSY, S_SETUP, S_ACCESS, S_WAIT_LOCK, S_RESP
   } state_t;

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LS_LIM = CNT_W'(LOCK_STABLE);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_to_cnt, r_stab_cnt, w_to_next, w_stab_next, w_to_inc, w_stab_inc;
   logic             w_err;
   logic             r_lock_s1, r_lock_s2;
   logic             r_cmd_write, r_cmd_waitlock;
   logic [5:0]       r_cmd_addr;
   logic [7:0]       r_cmd_wdata;
   logic             r_cmd_ready, r_rsp_valid, r_rsp_err, r_ccc_preset_n;
   logic             r_psel, r_penable, r_pwrite;
   logic [7:0]       r_rsp_rdata, r_pwdata;
   logic [5:0]       r_paddr;

   // Saturating increments: counters never wrap.
   assign w_to_inc   = (r_to_cnt == '1)   ? r_to_cnt   : r_to_cnt + ONE;
   assign w_stab_inc = (r_stab_cnt == '1) ? r_stab_cnt : r_stab_cnt + ONE;

   always_comb begin
      w_next      = r_state;
      w_to_next   = r_to_cnt;
      w_stab_next = r_stab_cnt;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_to_next = '0;
            if (i_cmd_valid) w_next = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!i_busy) begin
               w_next = S_SETUP;
            end else begin
               w_to_next = w_to_inc;
               if (w_to_inc >= TO_LIM) begin
                  w_next = S_RESP;
                  w_err  = 1'b1;
               end
            end
         end
         S_SETUP: w_next = S_ACCESS;
         S_ACCESS: begin
            w_to_next   = '0;
            w_stab_next = '0;
            w_next      = r_cmd_waitlock ? S_WAIT_LOCK : S_RESP;
         end
         S_WAIT_LOCK: begin
            w_to_next   = w_to_inc;
            w_stab_next = r_lock_s2 ? w_stab_inc : '0;
            // Stability is tested before the timeout so a tie resolves as success.
            if (w_stab_next >= LS_LIM) begin
               w_next = S_RESP;
            end else if (w_to_inc >= TO_LIM) begin
               w_next = S_RESP;
               w_err  = 1'b1;
            end
         end
         S_RESP: if (i_rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_pclk) begin
      if (i_preset) begin
         r_state        <= S_IDLE;
         r_to_cnt       <= '0;
         r_stab_cnt     <= '0;
         r_lock_s1      <= 1'b0;
         r_lock_s2      <= 1'b0;
         r_cmd_write    <= 1'b0;
         r_cmd_waitlock <= 1'b0;
         r_cmd_addr     <= '0;
         r_cmd_wdata    <= '0;
         r_cmd_ready    <= 1'b1;
         r_rsp_valid    <= 1'b0;
         r_rsp_err      <= 1'b0;
         r_rsp_rdata    <= '0;
         r_ccc_preset_n <= 1'b0;
         r_psel         <= 1'b0;
         r_penable      <= 1'b0;
         r_pwrite       <= 1'b0;
         r_paddr        <= '0;
         r_pwdata       <= '0;
      end else begin
         r_state        <= w_next;
         r_to_cnt       <= w_to_next;
         r_stab_cnt     <= w_stab_next;
         r_lock_s1      <= i_lock;
         r_lock_s2      <= r_lock_s1;
         r_ccc_preset_n <= 1'b1;
         r_cmd_ready    <= (w_next == S_IDLE);
         r_psel         <= (w_next == S_SETUP) || (w_next == S_ACCESS);
         r_penable      <= (w_next == S_ACCESS);
         r_rsp_valid    <= (w_next == S_RESP);
         if (r_state == S_IDLE && i_cmd_valid) begin
            r_cmd_write    <= i_cmd_write;
            r_cmd_waitlock <= i_cmd_waitlock;
            r_cmd_addr     <= i_cmd_addr;
            r_cmd_wdata    <= i_cmd_wdata;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
         end
         if (w_next == S_SETUP) begin
            r_pwrite <= r_cmd_write;
            r_paddr  <= r_cmd_addr;
            r_pwdata <= r_cmd_wdata;
         end
         if (r_state == S_ACCESS && !r_cmd_write) r_rsp_rdata <= i_prdata;
         if (w_err) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
         end
      end
   end

   assign o_cmd_ready    = r_cmd_ready;
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_rdata    = r_rsp_rdata;
   assign o_rsp_err      = r_rsp_err;
   assign o_ccc_preset_n = r_ccc_preset_n;
   assign o_psel         = r_psel;
   assign o_penable      = r_penable;
   assign o_pwrite       = r_pwrite;
   assign o_paddr        = r_paddr;
   assign o_pwdata       = r_pwdata;

endmodule

// File: tb/tb_fccc_apb_reconfig_master.sv
// Bench for fccc_apb_reconfig_master: directed table, hand-written reset sequences, random commands vs model.
module tb_fccc_apb_reconfig_master;

   localparam int TOUT  = 20;
   localparam int LSTAB = 4;
   localparam int TOUT8 = 8;

   logic       pclk = 1'b0;
   logic       preset = 1'b1;
   logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_waitlock = 1'b0;
   logic [5:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0, prdata = '0;
   logic       rsp_ready = 1'b0, busy = 1'b0, lock = 1'b0;

   logic       cmd_ready, rsp_valid, rsp_err, ccc_preset_n, psel, penable, pwrite;
   logic [7:0] rsp_rdata, pwdata;
   logic [5:0] paddr;
   logic       cmd_ready8, rsp_valid8, rsp_err8, ccc_preset_n8, psel8, penable8, pwrite8;
   logic [7:0] rsp_rdata8, pwdata8;
   logic [5:0] paddr8;

   int tests = 0;
   int fails = 0;
   logic lock_wave [0:63];

   always #5 pclk = ~pclk;

   fccc_apb_reconfig_master #(.LOCK_STABLE(LSTAB), .TIMEOUT(TOUT), .CNT_W(16)) u_dut (
      .i_pclk(pclk), .i_preset(preset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .i_cmd_waitlock(cmd_waitlock), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_ccc_preset_n(ccc_preset_n),
      .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
      .o_pwdata(pwdata), .i_prdata(prdata), .i_busy(busy), .i_lock(lock));

   // Second instance with a short BUSY timeout, sharing every input.
   fccc_apb_reconfig_master #(.LOCK_STABLE(LSTAB), .TIMEOUT(TOUT8), .CNT_W(4)) u_dut8 (
      .i_pclk(pclk), .i_preset(preset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready8),
      .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .i_cmd_waitlock(cmd_waitlock), .o_rsp_valid(rsp_valid8), .i_rsp_ready(rsp_ready),
      .o_rsp_rdata(rsp_rdata8), .o_rsp_err(rsp_err8), .o_ccc_preset_n(ccc_preset_n8),
      .o_psel(psel8), .o_penable(penable8), .o_pwrite(pwrite8), .o_paddr(paddr8),
      .o_pwdata(pwdata8), .i_prdata(prdata), .i_busy(busy), .i_lock(lock));

   typedef struct {
      logic       write;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic       waitlock;
      int         busy;     // cycles BUSY stays high after accept
      logic [7:0] prdata;
      int         lmode;    // 0 high, 1 low, 2 drop/glitch pattern, 3 random
      int         hold;     // extra cycles RSP_READY stays low
      logic       chk8;
      int         resp_e;   // edges after accept until RSP_VALID is seen
      logic       err;
      logic [7:0] rdata;
   } txn_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic fill_lock(input int mode);
      for (int i = 0; i < 64; i++) begin
         case (mode)
            0:       lock_wave[i] = 1'b1;
            1:       lock_wave[i] = 1'b0;
            2:       lock_wave[i] = !((i >= 4 && i <= 13) || i == 16);
            default: lock_wave[i] = ($urandom_range(0, 3) != 0);
         endcase
      end
   endtask

   // Reference: APB access needs BUSY low within TIMEOUT cycles; the lock wait succeeds on the
   // first run of LSTAB synchronized-high samples inside a TOUT-cycle window (tie -> success).
   task automatic model(inout txn_t t);
      int run;
      if (t.busy >= TOUT) begin
         t.resp_e = TOUT; t.err = 1'b1; t.rdata = 8'h00;
         return;
      end
      t.err   = 1'b0;
      t.rdata = t.write ? 8'h00 : t.prdata;
      if (!t.waitlock) begin
         t.resp_e = t.busy + 3;
         return;
      end
      run = 0;
      for (int j = 1; j <= TOUT; j++) begin
         run = lock_wave[t.busy + j] ? run + 1 : 0;
         if (run >= LSTAB) begin
            t.resp_e = t.busy + 3 + j;
            return;
         end
      end
      t.resp_e = t.busy + 3 + TOUT; t.err = 1'b1; t.rdata = 8'h00;
   endtask

   task automatic run_txn(input txn_t t);
      int  waited;
      int  last;
      logic berr, psel_x, pen_x;
      waited = 0;
      while (!(cmd_ready && cmd_ready8) && waited < 60) begin
         step();
         waited++;
      end
      if (waited >= 60) chk("idle_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr;
      cmd_wdata = t.wdata; cmd_waitlock = t.waitlock;
      busy = (t.busy > 0);
      step();
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 6'($urandom);
      cmd_wdata = 8'($urandom); cmd_waitlock = 1'($urandom);
      berr = (t.busy >= TOUT);
      last = t.resp_e + t.hold;
      for (int e = 0; e <= last; e++) begin
         psel_x = !berr && (e == t.busy + 1 || e == t.busy + 2);
         pen_x  = !berr && (e == t.busy + 2);
         chk("ctl", 32'({cmd_ready, psel, penable, rsp_valid}),
             32'({1'b0, psel_x, pen_x, (e >= t.resp_e)}));
         if (psel_x) chk("apb", 32'({pwrite, paddr, pwdata}), 32'({t.write, t.addr, t.wdata}));
         if (e >= t.resp_e) chk("rsp", 32'({rsp_err, rsp_rdata}), 32'({t.err, t.rdata}));
         if (t.chk8) begin
            chk("t8_ctl", 32'({psel8, rsp_valid8}), 32'({1'b0, (e >= TOUT8)}));
            if (e >= TOUT8) chk("t8_err", 32'(rsp_err8), 32'd1);
         end
         busy   = (e < t.busy);
         lock   = lock_wave[e];
         prdata = (!berr && e == t.busy + 2) ? t.prdata : 8'($urandom);
         if (e == last) begin
            rsp_ready = 1'b1;
            cmd_valid = 1'b1;   // must not be taken in the response-accept cycle
         end
         step();
      end
      chk("release", 32'({cmd_ready, rsp_valid}), 32'({1'b1, 1'b0}));
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   function automatic txn_t mk(input logic w, input logic [5:0] a, input logic [7:0] d,
                               input logic wl, input int b, input logic [7:0] pr, input int lm,
                               input int h, input logic c8, input int re, input logic er,
                               input logic [7:0] rd);
      txn_t t;
      t.write = w; t.addr = a; t.wdata = d; t.waitlock = wl; t.busy = b; t.prdata = pr;
      t.lmode = lm; t.hold = h; t.chk8 = c8; t.resp_e = re; t.err = er; t.rdata = rd;
      return t;
   endfunction

   txn_t vec [9];
   txn_t rt;

   initial begin
      vec[0] = mk(1'b1, 6'h05, 8'hA3, 1'b0,  0, 8'h00, 0, 0, 1'b0,  3, 1'b0, 8'h00);
      vec[1] = mk(1'b0, 6'h2A, 8'h00, 1'b0,  0, 8'h5C, 0, 5, 1'b0,  3, 1'b0, 8'h5C);
      vec[2] = mk(1'b1, 6'h11, 8'h3C, 1'b0,  3, 8'h00, 0, 1, 1'b0,  6, 1'b0, 8'h00);
      vec[3] = mk(1'b0, 6'h3F, 8'h00, 1'b0, 19, 8'h81, 0, 0, 1'b0, 22, 1'b0, 8'h81);
      vec[4] = mk(1'b1, 6'h07, 8'hFF, 1'b0, 25, 8'h00, 0, 2, 1'b1, 20, 1'b1, 8'h00);
      vec[5] = mk(1'b0, 6'h01, 8'h00, 1'b1,  0, 8'h66, 0, 0, 1'b0,  7, 1'b0, 8'h66);
      vec[6] = mk(1'b0, 6'h02, 8'h00, 1'b1,  0, 8'h99, 1, 1, 1'b0, 23, 1'b1, 8'h00);
      vec[7] = mk(1'b1, 6'h0C, 8'h5A, 1'b1,  0, 8'h00, 2, 0, 1'b0, 23, 1'b0, 8'h00);
      vec[8] = mk(1'b0, 6'h33, 8'h00, 1'b1,  2, 8'hC7, 0, 0, 1'b0,  9, 1'b0, 8'hC7);

      // Reset state
      preset = 1'b1;
      step(); step();
      chk("rst_out", 32'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite}),
          32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}));
      chk("rst_apb", 32'({paddr, pwdata}), 32'd0);
      chk("rst_cccn", 32'(ccc_preset_n), 32'd0);
      preset = 1'b0;
      #1;
      chk("rst_cccn_rel", 32'(ccc_preset_n), 32'd0);
      step();
      chk("cccn_up", 32'(ccc_preset_n), 32'd1);
      step();

      for (int i = 0; i < 9; i++) begin
         fill_lock(vec[i].lmode);
         run_txn(vec[i]);
      end

      for (int n = 0; n < 40; n++) begin
         rt.write = 1'($urandom); rt.addr = 6'($urandom); rt.wdata = 8'($urandom);
         rt.prdata = 8'($urandom); rt.waitlock = 1'($urandom);
         rt.busy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 23))
                                                : int'($urandom_range(0, 6));
         rt.lmode = ($urandom_range(0, 3) == 0) ? 1 : 3;
         rt.hold = int'($urandom_range(0, 3));
         rt.chk8 = 1'b0;
         fill_lock(rt.lmode);
         model(rt);
         run_txn(rt);
      end

      // PRESET during SETUP aborts the access silently
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h15; cmd_wdata = 8'h42;
      cmd_waitlock = 1'b0; busy = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      chk("mid_setup", 32'({psel, penable}), 32'({1'b1, 1'b0}));
      preset = 1'b1;
      step();
      chk("mid_rst", 32'({psel, penable, rsp_valid, cmd_ready, ccc_preset_n}),
          32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
      preset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("post_rst", 32'({psel, rsp_valid, cmd_ready}), 32'({1'b0, 1'b0, 1'b1}));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
